// File: rtl/layer_result_drain.sv
// Snapshots a parallel layer accumulator bus and streams the words out
// one per handshake, with back-to-back reload, abort and overrun flag.
module layer_result_drain #(
    parameter int NUM_NEURONS = 4,
    parameter int BIT_WIDTH   = 32,
    parameter int EXTRA_BITS  = 2,
    parameter int IDX_W       = 8
) (
    input  logic                                         CLK,
    input  logic                                         RESET_N,
    input  logic [(BIT_WIDTH+EXTRA_BITS)*NUM_NEURONS-1:0] ACC_RESULT,
    input  logic                                         CAPTURE,
    input  logic                                         CLEAR,
    input  logic                                         OUT_READY,
    output logic [BIT_WIDTH+EXTRA_BITS-1:0]              OUT_DATA,
    output logic                                         OUT_VALID,
    output logic [IDX_W-1:0]                             OUT_INDEX,
    output logic                                         OUT_LAST,
    output logic                                         BUSY,
    output logic                                         DONE,
    output logic                                         OVERRUN
);

    localparam int W = BIT_WIDTH + EXTRA_BITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    state_t                            state_q, state_d;
    logic [IDX_W-1:0]                  idx_q, idx_d;
    logic [NUM_NEURONS-1:0][W-1:0]     shadow_q, shadow_d;
    logic                              done_q, done_d;
    logic                              overrun_q, overrun_d;

    logic         drain;
    logic         last;
    logic         xfer;
    logic         last_xfer;
    logic         accept;
    logic [W-1:0] data_mux;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            shadow_q  <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        drain     = (state_q == DRAIN);
        last      = drain && (idx_q == LAST_IDX);
        xfer      = drain && OUT_READY;
        last_xfer = xfer && last;
        // A capture may ride on the final handshake to avoid a valid gap.
        accept    = CAPTURE && !CLEAR && (!drain || last_xfer);

        state_d   = state_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;

        if (CLEAR) begin
            state_d   = IDLE;
            idx_d     = '0;
            overrun_d = 1'b0;
        end else begin
            done_d = last_xfer;
            if (accept) begin
                shadow_d = ACC_RESULT;
                idx_d    = '0;
                state_d  = DRAIN;
            end else if (last_xfer) begin
                state_d = IDLE;
                idx_d   = '0;
            end else if (xfer) begin
                idx_d = idx_q + 1'b1;
            end
            if (CAPTURE && !accept) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_comb begin
        data_mux = '0;
        for (int s = 0; s < NUM_NEURONS; s++) begin
            if (idx_q == IDX_W'(s)) begin
                data_mux = shadow_q[s];
            end
        end
    end

    assign OUT_DATA  = data_mux;
    assign OUT_VALID = (state_q == DRAIN);
    assign OUT_INDEX = idx_q;
    assign OUT_LAST  = (state_q == DRAIN) && (idx_q == LAST_IDX);
    assign BUSY      = (state_q == DRAIN);
    assign DONE      = done_q;
    assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_layer_result_drain.sv
// Directed bench: table of per-cycle inputs and expected outputs,
// plus hand sequences for async reset and the single-neuron build.
module tb_layer_result_drain;

    localparam int W = 34;
    localparam int N = 4;

    localparam logic [W-1:0] A0 = 34'h0_3F800000;
    localparam logic [W-1:0] A1 = 34'h0_40000000;
    localparam logic [W-1:0] A2 = 34'h0_40400000;
    localparam logic [W-1:0] A3 = 34'h0_40800000;
    localparam logic [W-1:0] B0 = 34'h1_11111111;
    localparam logic [W-1:0] B1 = 34'h2_22222222;
    localparam logic [W-1:0] B2 = 34'h3_33333333;
    localparam logic [W-1:0] B3 = 34'h0_44444444;
    localparam logic [W-1:0] CX = 34'h2_DEADBEEF;
    localparam logic [W*N-1:0] AV = {A3, A2, A1, A0};
    localparam logic [W*N-1:0] BV = {B3, B2, B1, B0};
    localparam logic [W*N-1:0] CV = {CX, CX, CX, CX};

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [W*N-1:0] acc = '0;
    logic           cap = 1'b0;
    logic           clr = 1'b0;
    logic           rdy = 1'b0;
    logic [W-1:0]   odata;
    logic           ovalid;
    logic [7:0]     oidx;
    logic           olast;
    logic           busy;
    logic           done;
    logic           ovr;

    logic [W-1:0]   acc1 = '0;
    logic           cap1 = 1'b0;
    logic [W-1:0]   odata1;
    logic           ovalid1;
    logic [7:0]     oidx1;
    logic           olast1;
    logic           busy1;
    logic           done1;
    logic           ovr1;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    layer_result_drain #(.NUM_NEURONS(4)) dut (
        .CLK(clk), .RESET_N(rst_n), .ACC_RESULT(acc),
        .CAPTURE(cap), .CLEAR(clr), .OUT_READY(rdy),
        .OUT_DATA(odata), .OUT_VALID(ovalid), .OUT_INDEX(oidx),
        .OUT_LAST(olast), .BUSY(busy), .DONE(done), .OVERRUN(ovr)
    );

    layer_result_drain #(.NUM_NEURONS(1)) dut1 (
        .CLK(clk), .RESET_N(rst_n), .ACC_RESULT(acc1),
        .CAPTURE(cap1), .CLEAR(1'b0), .OUT_READY(1'b1),
        .OUT_DATA(odata1), .OUT_VALID(ovalid1), .OUT_INDEX(oidx1),
        .OUT_LAST(olast1), .BUSY(busy1), .DONE(done1), .OVERRUN(ovr1)
    );

    typedef struct {
        logic [W*N-1:0] acc;
        logic           cap;
        logic           clr;
        logic           rdy;
        logic           ev;
        logic [7:0]     eidx;
        logic [W-1:0]   edata;
        logic           elast;
        logic           edone;
        logic           eov;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(
        input logic [W*N-1:0] a, input logic c, input logic cl,
        input logic r, input logic v, input logic [7:0] i,
        input logic [W-1:0] d, input logic l, input logic dn,
        input logic o);
        vec_t t;
        t.acc = a; t.cap = c; t.clr = cl; t.rdy = r; t.ev = v;
        t.eidx = i; t.edata = d; t.elast = l; t.edone = dn; t.eov = o;
        return t;
    endfunction

    task automatic chk(input string nm, input int id,
                       input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got %h want %h", nm, id, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // REQ-034 straight drain
        tv.push_back(mk(AV, 1, 0, 1, 0, 0, 0,  0, 0, 0));
        tv.push_back(mk(AV, 0, 0, 1, 1, 0, A0, 0, 0, 0));
        tv.push_back(mk(AV, 0, 0, 1, 1, 1, A1, 0, 0, 0));
        tv.push_back(mk(AV, 0, 0, 1, 1, 2, A2, 0, 0, 0));
        tv.push_back(mk(AV, 0, 0, 1, 1, 3, A3, 1, 0, 0));
        tv.push_back(mk(AV, 0, 0, 1, 0, 0, 0,  0, 1, 0));
        tv.push_back(mk(AV, 0, 0, 1, 0, 0, 0,  0, 0, 0));
        // REQ-035 stalls, input bus changed after capture
        tv.push_back(mk(BV, 1, 0, 1, 0, 0, 0,  0, 0, 0));
        tv.push_back(mk(CV, 0, 0, 1, 1, 0, B0, 0, 0, 0));
        tv.push_back(mk(CV, 0, 0, 0, 1, 1, B1, 0, 0, 0));
        tv.push_back(mk(CV, 0, 0, 0, 1, 1, B1, 0, 0, 0));
        tv.push_back(mk(CV, 0, 0, 1, 1, 1, B1, 0, 0, 0));
        tv.push_back(mk(CV, 0, 0, 1, 1, 2, B2, 0, 0, 0));
        tv.push_back(mk(CV, 0, 0, 0, 1, 3, B3, 1, 0, 0));
        tv.push_back(mk(CV, 0, 0, 0, 1, 3, B3, 1, 0, 0));
        tv.push_back(mk(CV, 0, 0, 1, 1, 3, B3, 1, 0, 0));
        tv.push_back(mk(CV, 0, 0, 1, 0, 0, 0,  0, 1, 0));
        // REQ-036 overrun then clear
        tv.push_back(mk(AV, 1, 0, 1, 0, 0, 0,  0, 0, 0));
        tv.push_back(mk(AV, 0, 0, 1, 1, 0, A0, 0, 0, 0));
        tv.push_back(mk(CV, 1, 0, 1, 1, 1, A1, 0, 0, 0));
        tv.push_back(mk(CV, 0, 0, 1, 1, 2, A2, 0, 0, 1));
        tv.push_back(mk(CV, 0, 1, 0, 1, 3, A3, 1, 0, 1));
        tv.push_back(mk(CV, 0, 0, 1, 0, 0, 0,  0, 0, 0));
        tv.push_back(mk(CV, 0, 0, 1, 0, 0, 0,  0, 0, 0));
        // REQ-037 back-to-back capture on last transfer
        tv.push_back(mk(AV, 1, 0, 1, 0, 0, 0,  0, 0, 0));
        tv.push_back(mk(CV, 0, 0, 1, 1, 0, A0, 0, 0, 0));
        tv.push_back(mk(CV, 0, 0, 1, 1, 1, A1, 0, 0, 0));
        tv.push_back(mk(CV, 0, 0, 1, 1, 2, A2, 0, 0, 0));
        tv.push_back(mk(BV, 1, 0, 1, 1, 3, A3, 1, 0, 0));
        tv.push_back(mk(CV, 0, 0, 1, 1, 0, B0, 0, 1, 0));
        tv.push_back(mk(CV, 0, 0, 1, 1, 1, B1, 0, 0, 0));
        tv.push_back(mk(CV, 0, 0, 1, 1, 2, B2, 0, 0, 0));
        tv.push_back(mk(CV, 0, 0, 1, 1, 3, B3, 1, 0, 0));
        tv.push_back(mk(CV, 0, 0, 1, 0, 0, 0,  0, 1, 0));
        tv.push_back(mk(CV, 0, 0, 1, 0, 0, 0,  0, 0, 0));

        tick();
        chk("rst_valid", 0, 64'(ovalid), 64'd0);
        chk("rst_data", 0, 64'(odata), 64'd0);
        chk("rst_ovr", 0, 64'(ovr), 64'd0);
        tick();
        rst_n = 1'b1;

        foreach (tv[i]) begin
            acc = tv[i].acc;
            cap = tv[i].cap;
            clr = tv[i].clr;
            rdy = tv[i].rdy;
            chk("valid", i, 64'(ovalid), 64'(tv[i].ev));
            chk("busy", i, 64'(busy), 64'(tv[i].ev));
            chk("done", i, 64'(done), 64'(tv[i].edone));
            chk("overrun", i, 64'(ovr), 64'(tv[i].eov));
            if (tv[i].ev) begin
                chk("index", i, 64'(oidx), 64'(tv[i].eidx));
                chk("data", i, 64'(odata), 64'(tv[i].edata));
                chk("last", i, 64'(olast), 64'(tv[i].elast));
            end
            tick();
        end
        cap = 1'b0;
        clr = 1'b0;

        // REQ-038 async reset mid-drain
        acc = AV; cap = 1'b1; rdy = 1'b1;
        tick();
        cap = 1'b0;
        tick();
        cap = 1'b1;
        tick();
        cap = 1'b0;
        chk("pre_rst_idx", 100, 64'(oidx), 64'd2);
        chk("pre_rst_ovr", 100, 64'(ovr), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 101, 64'(ovalid), 64'd0);
        chk("arst_busy", 101, 64'(busy), 64'd0);
        chk("arst_done", 101, 64'(done), 64'd0);
        chk("arst_ovr", 101, 64'(ovr), 64'd0);
        chk("arst_idx", 101, 64'(oidx), 64'd0);
        chk("arst_last", 101, 64'(olast), 64'd0);
        chk("arst_data", 101, 64'(odata), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        acc = BV; cap = 1'b1; rdy = 1'b0;
        tick();
        cap = 1'b0;
        chk("post_rst_valid", 102, 64'(ovalid), 64'd1);
        chk("post_rst_idx", 102, 64'(oidx), 64'd0);
        chk("post_rst_data", 102, 64'(odata), 64'(B0));
        rdy = 1'b1;
        repeat (5) tick();

        // REQ-039 single-neuron build
        acc1 = A2; cap1 = 1'b1;
        tick();
        cap1 = 1'b0;
        acc1 = CX;
        chk("n1_valid", 200, 64'(ovalid1), 64'd1);
        chk("n1_last", 200, 64'(olast1), 64'd1);
        chk("n1_idx", 200, 64'(oidx1), 64'd0);
        chk("n1_data", 200, 64'(odata1), 64'(A2));
        chk("n1_done0", 200, 64'(done1), 64'd0);
        tick();
        chk("n1_idle", 201, 64'(ovalid1), 64'd0);
        chk("n1_done", 201, 64'(done1), 64'd1);
        tick();
        chk("n1_done_end", 202, 64'(done1), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/layer_result_drain.md
LAYER_RESULT_DRAIN -- requirements
Module: layer_result_drain

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 4: number of neuron results captured per layer pass; legal range 1..256.
REQ-002 SHALL have parameter BIT_WIDTH, default 32: floating-point word size.
REQ-003 SHALL have parameter EXTRA_BITS, default 2: FloPoCo exception bits, legal values 0 or 2; W = BIT_WIDTH+EXTRA_BITS.
REQ-004 SHALL have parameter IDX_W, default 8: width of the neuron index output; must satisfy 2^IDX_W >= NUM_NEURONS.
REQ-005 SHALL have port CLK  input  1  single clock, all state updates on the rising edge.
REQ-006 SHALL have port RESET_N  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port ACC_RESULT  input  W*NUM_NEURONS  parallel layer accumulator bus; neuron s occupies bits [W*(s+1)-1 : W*s].
REQ-008 SHALL have port CAPTURE  input  1  one-cycle request to snapshot ACC_RESULT (accumulation complete).
REQ-009 SHALL have port CLEAR  input  1  synchronous abort of the drain in progress.
REQ-010 SHALL have port OUT_READY  input  1  downstream can accept a word.
REQ-011 SHALL have port OUT_DATA  output  W  current neuron result.
REQ-012 SHALL have port OUT_VALID  output  1  OUT_DATA, OUT_INDEX and OUT_LAST are valid.
REQ-013 SHALL have port OUT_INDEX  output  IDX_W  neuron number of OUT_DATA.
REQ-014 SHALL have port OUT_LAST  output  1  OUT_DATA is neuron NUM_NEURONS-1.
REQ-015 SHALL have port BUSY  output  1  registered; high while in DRAIN.
REQ-016 SHALL have port DONE  output  1  one-cycle pulse after the final word transfers.
REQ-017 SHALL have port OVERRUN  output  1  sticky flag; a CAPTURE was dropped.

Function
REQ-018 SHALL implement two states: IDLE and DRAIN.
REQ-019 SHALL accept a capture when CAPTURE=1, CLEAR=0 and either state=IDLE or the last-word handshake occurs in that cycle.
REQ-020 SHALL, on an accepted capture, register all of ACC_RESULT into a shadow buffer, set idx=0 and be in DRAIN on the next cycle.
REQ-021 SHALL drive OUT_VALID=1 whenever state=DRAIN; first valid cycle is the cycle after capture (latency 1).
REQ-022 SHALL drive OUT_DATA = shadow word idx, OUT_INDEX = idx, and OUT_LAST = (idx==NUM_NEURONS-1).
REQ-023 SHALL define a transfer as OUT_VALID & OUT_READY at a rising edge, and on each transfer increment idx.
REQ-024 SHALL hold OUT_DATA, OUT_INDEX and OUT_LAST stable while OUT_VALID=1 and OUT_READY=0.
REQ-025 SHALL, on the transfer with OUT_LAST=1 and no accepted capture, return to IDLE with OUT_VALID=0 the next cycle.
REQ-026 SHALL pulse DONE for exactly the one cycle following every last-word transfer, including the back-to-back case.
REQ-027 SHALL, on the back-to-back case (last transfer plus accepted capture in the same cycle), reload the shadow buffer, set idx=0 and remain in DRAIN with no OUT_VALID gap.
REQ-028 SHALL ignore any CAPTURE not accepted per REQ-019 (shadow buffer unchanged) and set OVERRUN=1 on the next cycle.
REQ-029 SHALL, on CLEAR=1, go to IDLE, set OUT_VALID=0, set idx=0 and OVERRUN=0 on the next cycle, generate no DONE, and ignore any simultaneous CAPTURE without flagging OVERRUN.
REQ-030 SHALL, with NUM_NEURONS=1, assert OUT_LAST on the only word.
REQ-031 SHALL never modify ACC_RESULT semantics; the data path is pure storage, with no arithmetic on words.

Reset
REQ-032 SHALL, on RESET_N=0 at any time (including mid-drain), immediately set state=IDLE, idx=0, OUT_VALID=0, BUSY=0, DONE=0, OVERRUN=0, OUT_INDEX=0, OUT_LAST=0, OUT_DATA=0 and shadow buffer=0.
REQ-033 SHALL accept no CAPTURE until the first rising edge after RESET_N deasserts.

Verification
REQ-034 SHALL be verified as follows: NUM_NEURONS=4 with ACC_RESULT words {0x0_3F800000, 0x0_40000000, 0x0_40400000, 0x0_40800000} and OUT_READY=1 -> four words on consecutive cycles, indices 0..3, OUT_LAST only on index 3, DONE one cycle later.
REQ-035 SHALL be verified as follows: OUT_READY toggled 1,0,0,1,... with ACC_RESULT changed after capture -> OUT_DATA held during stalls and equal to the captured values; no word dropped or duplicated.
REQ-036 SHALL be verified as follows: CAPTURE during index 1 -> OVERRUN=1 next cycle, drained data unchanged; then CLEAR -> OUT_VALID=0 and OVERRUN=0, no DONE.
REQ-037 SHALL be verified as follows: CAPTURE coincident with the last transfer -> DONE pulses, OUT_VALID stays 1, next word is new neuron 0, OVERRUN stays 0.
REQ-038 SHALL be verified as follows: RESET_N asserted asynchronously mid-drain at index 2 -> all outputs 0 before the next edge; after release, a fresh capture drains from index 0.
REQ-039 SHALL be verified as follows: NUM_NEURONS=1 -> a single word with OUT_LAST=1, then DONE.
